// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the display path.
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef logic [5:0][3:0] bcd6_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment pattern.
// Non-decimal codes render as a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Pure lookup; dp stays off in every pattern.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd6_display_scan.sv
// Double-buffered 6-digit BCD capture driving a 4-digit
// multiplexed common-anode display through a movable window.
module bcd6_display_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_5,
    input  logic [3:0] bcd_4,
    input  logic [3:0] bcd_3,
    input  logic [3:0] bcd_2,
    input  logic [3:0] bcd_1,
    input  logic [3:0] bcd_0,
    input  logic       load,
    input  logic [1:0] win_sel,
    output logic       load_ready,
    output logic       frame_done,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          tick;
    logic          pending;
    bcd6_t         stage;
    bcd6_t         disp;
    logic [1:0]    win;
    logic [2:0]    pos;
    logic [3:0]    cur_digit;
    logic [7:0]    cur_seg;

    assign tick       = (cnt == CNT_MAX);
    assign frame_done = tick && (idx == 2'd3);
    assign load_ready = ~pending;

    // A window of 3 would run off the top digit; clamp to 2.
    assign win       = (win_sel == 2'd3) ? 2'd2 : win_sel;
    assign pos       = {1'b0, win} + {1'b0, idx};
    assign cur_digit = disp[pos];

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    // Prescaler and digit index advance together on each tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Stage absorbs loads; disp only changes at a frame boundary,
    // and a coincident load re-arms pending after the swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage   <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            if (frame_done && pending) begin
                disp    <= stage;
                pending <= 1'b0;
            end
            if (load) begin
                stage   <= {bcd_5, bcd_4, bcd_3, bcd_2, bcd_1, bcd_0};
                pending <= 1'b1;
            end
        end
    end

    // Registered pins so an and seg always switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= cur_seg;
        end
    end

endmodule
